// File: rtl/rr_arb_pkg.sv
// Shared constants, FSM state type and helpers for the eight-way round-robin arbiter.
package rr_arb_pkg;

    localparam int N    = 8;
    localparam int IDXW = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Expand a binary requester index to its one-hot position.
    function automatic logic [N-1:0] onehot(input logic [IDXW-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: lowest set bit of v at or above ptr, wrapping to the
// lowest set bit overall when nothing at or above ptr is set.
module rr_pick
    import rr_arb_pkg::*;
(
    input  logic [N-1:0]    v,
    input  logic [IDXW-1:0] ptr,
    output logic [IDXW-1:0] idx,
    output logic            found
);

    logic [N-1:0]    w_masked;
    logic [IDXW-1:0] w_masked_idx;
    logic [IDXW-1:0] w_fallback_idx;

    assign w_masked = v & ({N{1'b1}} << ptr);

    // Two lowest-index-first priority encoders: one over the masked vector,
    // one over the full vector for the wrap case.
    always_comb begin
        w_masked_idx   = '0;
        w_fallback_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_masked[i]) begin
                w_masked_idx = IDXW'(i);
            end
            if (v[i]) begin
                w_fallback_idx = IDXW'(i);
            end
        end
    end

    assign idx   = (|w_masked) ? w_masked_idx : w_fallback_idx;
    assign found = |v;

endmodule

// File: rtl/rr_arb8.sv
// Eight-way round-robin arbiter with a hold limit under contention.
// Handshake: req[i] is a level request held while requester i wants the
// resource; gnt/gnt_idx/gnt_valid are registered and change only on clk.
// dbg_state/dbg_ptr expose the FSM state and search pointer for checkers.
module rr_arb8
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            dbg_state,
    output logic [IDXW-1:0] dbg_ptr
);

    localparam int HCW = $clog2(MAX_HOLD + 1);
    localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD);

    state_t          r_state;
    logic [IDXW-1:0] r_ptr;
    logic [IDXW-1:0] r_owner;
    logic [HCW-1:0]  r_hold;
    logic [N-1:0]    r_gnt;
    logic [IDXW-1:0] r_gnt_idx;
    logic            r_gnt_valid;

    state_t          w_state_nx;
    logic [IDXW-1:0] w_ptr_nx;
    logic [IDXW-1:0] w_owner_nx;
    logic [HCW-1:0]  w_hold_nx;

    logic [N-1:0]    w_req_others;
    logic [IDXW-1:0] w_all_idx;
    logic            w_all_found;
    logic [IDXW-1:0] w_oth_idx;
    logic            w_oth_found;

    assign w_req_others = req & ~onehot(r_owner);

    // Candidate for a fresh arbitration (idle start or release).
    rr_pick u_pick_all (
        .v     (req),
        .ptr   (r_ptr),
        .idx   (w_all_idx),
        .found (w_all_found)
    );

    // Candidate for preemption: everyone except the current owner.
    rr_pick u_pick_oth (
        .v     (w_req_others),
        .ptr   (r_ptr),
        .idx   (w_oth_idx),
        .found (w_oth_found)
    );

    // Next-state logic: enable, then release, then hold-limit preemption.
    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_owner_nx = r_owner;
        w_hold_nx  = r_hold;
        case (r_state)
            IDLE: begin
                if (en && w_all_found) begin
                    w_state_nx = GRANT;
                    w_owner_nx = w_all_idx;
                    w_ptr_nx   = w_all_idx + IDXW'(1);
                    w_hold_nx  = HCW'(1);
                end
            end
            GRANT: begin
                if (!en) begin
                    w_state_nx = IDLE;
                end else if (!req[r_owner]) begin
                    if (w_all_found) begin
                        w_owner_nx = w_all_idx;
                        w_ptr_nx   = w_all_idx + IDXW'(1);
                        w_hold_nx  = HCW'(1);
                    end else begin
                        w_state_nx = IDLE;
                    end
                end else if ((r_hold == HOLD_MAX) && w_oth_found) begin
                    w_owner_nx = w_oth_idx;
                    w_ptr_nx   = w_oth_idx + IDXW'(1);
                    w_hold_nx  = HCW'(1);
                end else if (r_hold != HOLD_MAX) begin
                    w_hold_nx = r_hold + HCW'(1);
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // State and registered outputs; outputs follow the next state directly
    // so a grant appears one edge after the request is sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_hold      <= '0;
            r_gnt       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_ptr       <= w_ptr_nx;
            r_owner     <= w_owner_nx;
            r_hold      <= w_hold_nx;
            r_gnt       <= (w_state_nx == GRANT) ? onehot(w_owner_nx) : '0;
            r_gnt_idx   <= (w_state_nx == GRANT) ? w_owner_nx : '0;
            r_gnt_valid <= (w_state_nx == GRANT);
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;
    assign dbg_state = (r_state == GRANT);
    assign dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_rr_arb8.sv
// Bench for rr_arb8: directed vector table (MAX_HOLD=4), full-load rotation
// (MAX_HOLD=1), then random traffic against a behavioural model on both.
module tb_rr_arb8;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;

    logic [7:0] g4, g1;
    logic [2:0] i4, i1;
    logic       v4, v1;
    logic       s4, s1;
    logic [2:0] p4, p1;

    int errors = 0;
    int checks = 0;

    rr_arb8 #(.MAX_HOLD(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(g4), .gnt_idx(i4), .gnt_valid(v4),
        .dbg_state(s4), .dbg_ptr(p4)
    );

    rr_arb8 #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(g1), .gnt_idx(i1), .gnt_valid(v1),
        .dbg_state(s1), .dbg_ptr(p1)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_gnt(input logic vld, input int idx);
        logic [7:0] one;
        one = 8'd1;
        return vld ? (one << idx) : 8'd0;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    int mh[2]     = '{4, 1};
    bit m_act[2];
    int m_owner[2];
    int m_ptr[2];
    int m_hold[2];

    // Rotating search starting at ptr; -1 when v is empty.
    function automatic int rr_search(input logic [7:0] v, input int ptr);
        for (int k = 0; k < 8; k++) begin
            int j;
            j = (ptr + k) % 8;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_grant(input int k, input int who);
        m_act[k]   = 1'b1;
        m_owner[k] = who;
        m_ptr[k]   = (who + 1) % 8;
        m_hold[k]  = 1;
    endtask

    task automatic model_step(input int k);
        logic [7:0] others;
        if (rst) begin
            m_act[k] = 1'b0; m_ptr[k] = 0; m_owner[k] = 0; m_hold[k] = 0;
        end else if (!m_act[k]) begin
            if (en && req != 8'd0) model_grant(k, rr_search(req, m_ptr[k]));
        end else if (!en) begin
            m_act[k] = 1'b0;
        end else if (!req[m_owner[k]]) begin
            if (req != 8'd0) model_grant(k, rr_search(req, m_ptr[k]));
            else m_act[k] = 1'b0;
        end else begin
            others = req;
            others[m_owner[k]] = 1'b0;
            if (m_hold[k] >= mh[k] && others != 8'd0)
                model_grant(k, rr_search(others, m_ptr[k]));
            else if (m_hold[k] < mh[k])
                m_hold[k]++;
        end
    endtask

    task automatic model_compare(input int k, input logic [7:0] g, input logic [2:0] idx,
                                 input logic vld, input logic [2:0] ptr);
        string tag;
        tag = (k == 0) ? "rnd_h4" : "rnd_h1";
        chk({tag, "_valid"}, int'(vld), int'(m_act[k]));
        chk({tag, "_idx"}, int'(idx), m_act[k] ? m_owner[k] : 0);
        chk({tag, "_gnt"}, int'(g), int'(exp_gnt(m_act[k], m_owner[k])));
        chk({tag, "_ptr"}, int'(ptr), m_ptr[k]);
    endtask

    // ---------------- directed vectors (MAX_HOLD = 4) ----------------
    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] req;
        int         idx;
        logic       vld;
        int         ptr;
    } vec_t;

    localparam int NV = 28;
    vec_t tbl[NV];

    initial begin
        rst = 1'b1; en = 1'b0; req = 8'd0;

        // reset state / first grant / preemption 2<->5
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 0, 1'b0, 0};
        tbl[1]  = '{1'b0, 1'b1, 8'h24, 2, 1'b1, 3};
        tbl[2]  = '{1'b0, 1'b1, 8'h24, 2, 1'b1, 3};
        tbl[3]  = '{1'b0, 1'b1, 8'h24, 2, 1'b1, 3};
        tbl[4]  = '{1'b0, 1'b1, 8'h24, 2, 1'b1, 3};
        tbl[5]  = '{1'b0, 1'b1, 8'h24, 5, 1'b1, 6};
        tbl[6]  = '{1'b0, 1'b1, 8'h24, 5, 1'b1, 6};
        tbl[7]  = '{1'b0, 1'b1, 8'h24, 5, 1'b1, 6};
        tbl[8]  = '{1'b0, 1'b1, 8'h24, 5, 1'b1, 6};
        tbl[9]  = '{1'b0, 1'b1, 8'h24, 2, 1'b1, 3};
        tbl[10] = '{1'b0, 1'b1, 8'h24, 2, 1'b1, 3};
        tbl[11] = '{1'b0, 1'b1, 8'h24, 2, 1'b1, 3};
        tbl[12] = '{1'b0, 1'b1, 8'h24, 2, 1'b1, 3};
        tbl[13] = '{1'b0, 1'b1, 8'h24, 5, 1'b1, 6};
        // owner 5 releases, only req[1]: wraps with no bubble
        tbl[14] = '{1'b0, 1'b1, 8'h02, 1, 1'b1, 2};
        // handover to 3, enable low, then all request -> 4
        tbl[15] = '{1'b0, 1'b1, 8'h08, 3, 1'b1, 4};
        tbl[16] = '{1'b0, 1'b0, 8'h08, 0, 1'b0, 4};
        tbl[17] = '{1'b0, 1'b1, 8'hFF, 4, 1'b1, 5};
        // handover to 6, reset mid-grant, then req[7]
        tbl[18] = '{1'b0, 1'b1, 8'h40, 6, 1'b1, 7};
        tbl[19] = '{1'b1, 1'b1, 8'h40, 0, 1'b0, 0};
        tbl[20] = '{1'b0, 1'b1, 8'h80, 7, 1'b1, 0};
        // sole requester saturates, newcomer preempts immediately
        tbl[21] = '{1'b0, 1'b1, 8'h80, 7, 1'b1, 0};
        tbl[22] = '{1'b0, 1'b1, 8'h80, 7, 1'b1, 0};
        tbl[23] = '{1'b0, 1'b1, 8'h80, 7, 1'b1, 0};
        tbl[24] = '{1'b0, 1'b1, 8'h80, 7, 1'b1, 0};
        tbl[25] = '{1'b0, 1'b1, 8'h80, 7, 1'b1, 0};
        tbl[26] = '{1'b0, 1'b1, 8'h81, 0, 1'b1, 1};
        // everyone releases -> idle, ptr kept
        tbl[27] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 1};

        #2;
        for (int i = 0; i < NV; i++) begin
            rst = tbl[i].rst; en = tbl[i].en; req = tbl[i].req;
            cycle();
            chk($sformatf("vec%0d_valid", i), int'(v4), int'(tbl[i].vld));
            chk($sformatf("vec%0d_idx", i), int'(i4), tbl[i].idx);
            chk($sformatf("vec%0d_gnt", i), int'(g4), int'(exp_gnt(tbl[i].vld, tbl[i].idx)));
            chk($sformatf("vec%0d_ptr", i), int'(p4), tbl[i].ptr);
        end

        // ---------------- full-load rotation (MAX_HOLD = 1) ----------------
        rst = 1'b1; en = 1'b0; req = 8'd0;
        cycle();
        chk("rot_reset_valid", int'(v1), 0);
        rst = 1'b0; en = 1'b1; req = 8'hFF;
        for (int c = 0; c < 9; c++) begin
            cycle();
            chk($sformatf("rot%0d_valid", c), int'(v1), 1);
            chk($sformatf("rot%0d_idx", c), int'(i1), c % 8);
            chk($sformatf("rot%0d_gnt", c), int'(g1), int'(exp_gnt(1'b1, c % 8)));
        end

        // ---------------- random traffic vs model ----------------
        rst = 1'b1; en = 1'b0; req = 8'd0;
        for (int k = 0; k < 2; k++) model_step(k);
        cycle();
        model_compare(0, g4, i4, v4, p4);
        model_compare(1, g1, i1, v1, p1);
        rst = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom_range(0, 255));
            else if ($urandom_range(0, 5) == 0) req[$urandom_range(0, 7)] = 1'b0;
            en  = ($urandom_range(0, 15) != 0);
            rst = ($urandom_range(0, 149) == 0);
            for (int k = 0; k < 2; k++) model_step(k);
            cycle();
            model_compare(0, g4, i4, v4, p4);
            model_compare(1, g1, i1, v1, p1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
